// File: rtl/tt_sweep_pkg.sv
// Shared types and width helpers for the truth-table sweep/capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Truth-table width for an n-input function.
    function automatic int tt_width(input int nin);
        return 1 << nin;
    endfunction

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int NIN_DEF = 4;
    localparam int TTW_DEF = tt_width(NIN_DEF);

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Request/result bundle between a sweep requester and tt_sweep_capture.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the capture block is idle.
//
// start/expect_tt : request a sweep and the truth table it must reproduce
// busy/done       : sweep in progress / one-cycle completion pulse
// tt/match/nbad/first_bad : captured table and comparison results
interface tt_sweep_capture_if #(
    parameter int NIN = 4
);
    import tt_sweep_pkg::*;

    localparam int TTW = tt_width(NIN);

    logic           start;
    logic [TTW-1:0] expect_tt;
    logic           busy;
    logic           done;
    logic [TTW-1:0] tt;
    logic           match;
    logic [NIN:0]   nbad;
    logic [NIN-1:0] first_bad;

    modport master (
        output start, expect_tt,
        input  busy, done, tt, match, nbad, first_bad
    );

    modport slave (
        input  start, expect_tt,
        output busy, done, tt, match, nbad, first_bad
    );

endinterface

// File: rtl/tt_minterm_ctr.sv
// Minterm index / settle counter pair that paces the truth-table sweep.
// Latency: sample strobe every SETTLE+1 cycles while enabled; idx steps after each sample.
// Backpressure: none; counts freely while en is high, clr restarts from minterm 0.
//
// Ports: clk, rst (sync, active-high), clr (restart), en (sweep running),
//        idx (current minterm, registered), sample (y valid this cycle),
//        last (sample of the final minterm).
module tt_minterm_ctr
    import tt_sweep_pkg::*;
#(
    parameter int NIN    = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    output logic [NIN-1:0] idx,
    output logic           sample,
    output logic           last
);

    localparam int                SC_W    = cnt_width(SETTLE + 1);
    localparam logic [SC_W-1:0]   SC_MAX  = SC_W'(SETTLE);
    localparam logic [NIN-1:0]    IDX_MAX = {NIN{1'b1}};

    logic [SC_W-1:0] sc;

    assign sample = en && (sc == SC_MAX);
    assign last   = sample && (idx == IDX_MAX);

    // idx returns to 0 after the final sample so that it reads 0 whenever
    // no sweep is running; the top drives x straight from this register.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
            sc  <= '0;
        end else if (sample) begin
            sc  <= '0;
            idx <= last ? '0 : idx + NIN'(1);
        end else if (en) begin
            sc  <= sc + SC_W'(1);
        end
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps x through all minterms of a NIN-input function, captures y into a truth table, compares to expect_tt.
// Latency: accepted start to done = TTW*(SETTLE+1) + 1 cycles.
// Backpressure: none; start is ignored outside IDLE (no queuing).
//
// Ports: clk, rst (sync, active-high), bus (slave side of tt_sweep_capture_if),
//        x (function inputs, registered), y (function output).
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int NIN    = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    tt_sweep_capture_if.slave bus,
    output logic [NIN-1:0]  x,
    input  logic            y
);

    localparam int TTW = tt_width(NIN);

    state_t         state, state_nxt;
    logic           busy_c, done_c;
    logic           accept, run_en;
    logic [NIN-1:0] idx;
    logic           sample, last;

    logic [TTW-1:0] exp_q;
    logic [TTW-1:0] tt_q;
    logic [TTW-1:0] tt_smp;
    logic           mism;
    logic           match_q;
    logic [NIN:0]   nbad_q;
    logic [NIN-1:0] first_bad_q;

    assign accept = (state == IDLE) && bus.start;
    assign run_en = (state == RUN);

    tt_minterm_ctr #(
        .NIN    (NIN),
        .SETTLE (SETTLE)
    ) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (run_en),
        .idx    (idx),
        .sample (sample),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (last) state_nxt = FIN;
            end
            FIN: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Table as it will look after this cycle's sample; used both for the
    // capture and for the final compare so match includes the last minterm.
    always_comb begin
        tt_smp      = tt_q;
        tt_smp[idx] = y;
        mism        = (y != exp_q[idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q       <= '0;
            tt_q        <= '0;
            match_q     <= 1'b0;
            nbad_q      <= '0;
            first_bad_q <= '0;
        end else if (accept) begin
            exp_q       <= bus.expect_tt;
            tt_q        <= '0;
            match_q     <= 1'b0;
            nbad_q      <= '0;
            first_bad_q <= '0;
        end else if (sample) begin
            tt_q <= tt_smp;
            if (mism) begin
                nbad_q <= nbad_q + (NIN+1)'(1);
                // Minterms are visited in ascending order, so the first
                // mismatch seen is the lowest mismatching index.
                if (nbad_q == '0) first_bad_q <= idx;
            end
            if (last) match_q <= (tt_smp == exp_q);
        end
    end

    assign x             = idx;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.tt        = tt_q;
    assign bus.match     = match_q;
    assign bus.nbad      = nbad_q;
    assign bus.first_bad = first_bad_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: one instance with SETTLE=1 (a) and one with SETTLE=0 (b).
// Latency: checks start-to-done = 16*(SETTLE+1)+1 cycles and per-cycle x sequencing.
// Backpressure: exercises start ignored in RUN/FIN and accepted the cycle after done.
module tb_tt_sweep_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [3:0]  x_a, x_b;
    logic        y_a, y_b;
    int          mode;
    logic [15:0] tbl;

    int n_cmp = 0;
    int n_bad = 0;

    tt_sweep_capture_if #(.NIN(4)) bus_a ();
    tt_sweep_capture_if #(.NIN(4)) bus_b ();

    tt_sweep_capture #(.NIN(4), .SETTLE(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a),
        .x   (x_a),
        .y   (y_a)
    );

    tt_sweep_capture #(.NIN(4), .SETTLE(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b),
        .x   (x_b),
        .y   (y_b)
    );

    // Reference functions: 0 AND4, 1 XOR4, 2 x0, otherwise random table.
    function automatic logic fmodel(input int md, input logic [3:0] xv, input logic [15:0] t);
        case (md)
            0:       return &xv;
            1:       return ^xv;
            2:       return xv[0];
            default: return t[xv];
        endcase
    endfunction

    always_comb y_a = fmodel(mode, x_a, tbl);
    always_comb y_b = fmodel(mode, x_b, tbl);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // s selects the instance: 1 -> SETTLE=1 (a), 0 -> SETTLE=0 (b).
    task automatic set_start(input int s, input logic v, input logic [15:0] e);
        if (s == 1) begin bus_a.start = v; bus_a.expect_tt = e; end
        else        begin bus_b.start = v; bus_b.expect_tt = e; end
    endtask

    function automatic logic g_busy(input int s);  return (s == 1) ? bus_a.busy : bus_b.busy; endfunction
    function automatic logic g_done(input int s);  return (s == 1) ? bus_a.done : bus_b.done; endfunction
    function automatic logic [15:0] g_tt(input int s); return (s == 1) ? bus_a.tt : bus_b.tt; endfunction
    function automatic logic g_match(input int s); return (s == 1) ? bus_a.match : bus_b.match; endfunction
    function automatic logic [4:0] g_nbad(input int s); return (s == 1) ? bus_a.nbad : bus_b.nbad; endfunction
    function automatic logic [3:0] g_fb(input int s); return (s == 1) ? bus_a.first_bad : bus_b.first_bad; endfunction
    function automatic logic [3:0] g_x(input int s); return (s == 1) ? x_a : x_b; endfunction

    // Called at a negedge; asserts start there and follows the sweep to done.
    task automatic run_sweep(input int s, input logic [15:0] exp_v,
                             input bit pulse_run, input bit pulse_fin, input string tag);
        logic [15:0] tt_e;
        int          nb_e, fb_e, cyc, n_exp, xerr, berr;
        bit          seen;
        for (int m = 0; m < 16; m++) tt_e[m] = fmodel(mode, 4'(m), tbl);
        nb_e = 0; fb_e = 0;
        for (int m = 0; m < 16; m++)
            if (tt_e[m] != exp_v[m]) begin
                if (nb_e == 0) fb_e = m;
                nb_e++;
            end
        n_exp = 16 * (s + 1) + 1;
        cyc = 0; seen = 0; xerr = 0; berr = 0;
        set_start(s, 1'b1, exp_v);
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                set_start(s, 1'b0, exp_v);
                check({tag, " tt_cleared"}, 32'(g_tt(s)), 32'h0);
                check({tag, " nbad_cleared"}, 32'(g_nbad(s)), 32'h0);
            end
            if (g_done(s)) begin
                seen = 1;
            end else begin
                if (g_busy(s) !== 1'b1) berr++;
                if (g_x(s) !== 4'((cyc - 1) / (s + 1))) xerr++;
                if (pulse_run && cyc == 5) set_start(s, 1'b1, ~exp_v);
                if (pulse_run && cyc == 6) set_start(s, 1'b0, exp_v);
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'h1);
        check({tag, " latency"}, 32'(cyc), 32'(n_exp));
        check({tag, " busy_during_run"}, 32'(berr), 32'h0);
        check({tag, " x_sequence"}, 32'(xerr), 32'h0);
        check({tag, " busy_at_done"}, 32'(g_busy(s)), 32'h0);
        check({tag, " tt"}, 32'(g_tt(s)), 32'(tt_e));
        check({tag, " match"}, 32'(g_match(s)), 32'(tt_e == exp_v));
        check({tag, " nbad"}, 32'(g_nbad(s)), 32'(nb_e));
        check({tag, " first_bad"}, 32'(g_fb(s)), 32'(fb_e));
        if (pulse_fin) set_start(s, 1'b1, ~exp_v);
        @(negedge clk);
        if (pulse_fin) begin
            set_start(s, 1'b0, exp_v);
            for (int k = 0; k < 3; k++) begin
                check({tag, " fin_start_ignored"}, 32'(g_busy(s)), 32'h0);
                @(negedge clk);
            end
        end
        check({tag, " done_one_cycle"}, 32'(g_done(s)), 32'h0);
        check({tag, " tt_hold"}, 32'(g_tt(s)), 32'(tt_e));
    endtask

    initial begin
        int          cnt;
        bit          found;
        logic [15:0] e;
        int          s;

        rst_a = 1'b1; rst_b = 1'b1;
        mode = 0; tbl = 16'h0;
        set_start(1, 1'b0, 16'h0);
        set_start(0, 1'b0, 16'h0);
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst busy", 32'(bus_a.busy), 32'h0);
        check("rst done", 32'(bus_a.done), 32'h0);
        check("rst x", 32'(x_a), 32'h0);
        check("rst tt", 32'(bus_a.tt), 32'h0);
        check("rst match", 32'(bus_a.match), 32'h0);
        check("rst nbad", 32'(bus_a.nbad), 32'h0);
        check("rst first_bad", 32'(bus_a.first_bad), 32'h0);
        check("rst_b x", 32'(x_b), 32'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Directed functions.
        mode = 0; run_sweep(1, 16'h8000, 0, 0, "and4");
        mode = 1; run_sweep(1, 16'h6996, 0, 0, "xor4");
        mode = 0; run_sweep(1, 16'h8001, 0, 0, "and4_8001");
        mode = 0; run_sweep(1, 16'h7FFF, 0, 0, "and4_7fff");
        mode = 2; run_sweep(0, 16'hAAAA, 0, 0, "x0_settle0");

        // Reset in the middle of a sweep.
        mode = 1;
        set_start(1, 1'b1, 16'h6996);
        @(negedge clk);
        set_start(1, 1'b0, 16'h6996);
        found = 0; cnt = 0;
        while (!found && cnt < 60) begin
            if (x_a == 4'd7) found = 1;
            else begin @(negedge clk); cnt++; end
        end
        check("midrst reach_m7", 32'(found), 32'h1);
        check("midrst tt_nonzero", 32'(bus_a.tt != 16'h0), 32'h1);
        rst_a = 1'b1;
        @(negedge clk);
        check("midrst busy", 32'(bus_a.busy), 32'h0);
        check("midrst x", 32'(x_a), 32'h0);
        check("midrst tt", 32'(bus_a.tt), 32'h0);
        check("midrst nbad", 32'(bus_a.nbad), 32'h0);
        rst_a = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus_a.done) cnt++;
            @(negedge clk);
        end
        check("midrst no_done", 32'(cnt), 32'h0);
        run_sweep(1, 16'h6996, 0, 0, "after_rst");

        // start during RUN and FIN ignored, then back-to-back start after done.
        mode = 0;
        run_sweep(1, 16'h8000, 1, 1, "ign_a");
        run_sweep(0, 16'h8000, 1, 1, "ign_b");
        mode = 1;
        run_sweep(1, 16'h6996, 0, 0, "b2b_first");
        mode = 2;
        run_sweep(1, 16'hAAAA, 0, 0, "b2b_second");

        // Random tables and expectations on both instances.
        mode = 3;
        for (int r = 0; r < 8; r++) begin
            tbl = 16'($urandom);
            s   = int'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       e = tbl;
                1:       e = tbl ^ (16'h1 << $urandom_range(0, 15));
                default: e = 16'($urandom);
            endcase
            run_sweep(s, e, bit'($urandom_range(0, 1)), 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequential stage directly downstream of, and wrapped around, a 4-input single-output exact-synthesis function block.
- Drives that block's inputs x0..x3 through all 2^NIN minterms and samples its output y0 per minterm.
- Assembles the resulting truth table and compares it against an expected NPN-class truth table.
- Used in simulation benches and on-chip self-check to confirm each generated netlist realises its target function.

Parameters:
- NIN, 4, number of function inputs; truth-table width TTW = 2^NIN.
- SETTLE, 1, extra cycles x is held before y is sampled (0 = sample in the same cycle x is driven).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sweep; accepted only in IDLE
- expect  input  TTW  expected truth table, bit i = f(minterm i); latched on accepted start
- x  output  NIN  function inputs; bit k drives xk of the function block
- y  input  1  function output y0
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  single-cycle pulse when the sweep completes
- tt  output  TTW  captured truth table
- match  output  1  tt == expect latch; valid from done until the next accepted start
- nbad  output  NIN+1  count of mismatching minterms (0..TTW)
- first_bad  output  NIN  lowest mismatching minterm index; 0 when nbad == 0

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - State = IDLE.
  - x, tt, nbad, first_bad = 0.
  - busy, done, match = 0.
  - exp_q = 0.
- States and transitions: IDLE -> RUN -> FIN -> IDLE.
- IDLE:
  - busy = 0; x = 0.
  - start = 1 latches expect into exp_q and clears tt, nbad, first_bad, match.
  - Same cycle: idx = 0, settle counter sc = 0, transition to RUN.
- RUN:
  - busy = 1; x = idx (registered, glitch-free).
  - While sc < SETTLE: sc increments.
  - When sc == SETTLE:
    - tt[idx] <= y.
    - If y != exp_q[idx]: nbad += 1, and first_bad <= idx if this is the first mismatch.
    - sc <= 0.
    - If idx == TTW-1, go to FIN; otherwise idx += 1.
- FIN:
  - busy = 0 and done = 1 for exactly one cycle.
  - match <= (tt_final == exp_q), where tt_final includes the last minterm's sample, computed combinationally in the sample cycle.
  - Next state IDLE.
- Latency: accepted start to done = TTW*(SETTLE+1) + 1 cycles. With defaults, 33 cycles.
- Outputs tt, match, nbad, first_bad hold their values after done until the next accepted start or rst.
- start while in RUN or FIN is ignored (no queuing). start in the cycle after done (IDLE) is accepted normally.
- idx never wraps past TTW-1; nbad saturates naturally at TTW (width NIN+1).
- rst mid-RUN aborts the sweep: all outputs return to their reset values; no done pulse.
- y is sampled only in the sample cycle (sc == SETTLE); y is don't-care in all other cycles and states.

Decomposition:
- Shared package tt_sweep_pkg:
  - State enum {IDLE, RUN, FIN}.
  - Functions deriving TTW and the counter widths from NIN.
  - Localparams for the default NIN = 4 truth-table width.
- One natural sub-module: tt_minterm_ctr, holding the idx/sc counter pair. It emits sample and last strobes.
- Comparison and capture logic stays in tt_sweep_capture.

Test Plan:
1. Bench model y = &x (AND4), expect = 16'h8000, SETTLE = 1 -> done at cycle 33 after start; tt = 16'h8000; match = 1; nbad = 0; first_bad = 0.
2. Model y = ^x (XOR4), expect = 16'h6996 -> tt = 16'h6996, match = 1. Separately, x sequence checked to step 0,0,1,1,...,15,15 (each value held 2 cycles).
3. Model AND4 with expect = 16'h8001 -> match = 0; nbad = 1; first_bad = 0. Repeat with expect = 16'h7FFF -> nbad = 16, first_bad = 0.
4. SETTLE = 0, model y = x[0] (expect 16'hAAAA) -> start-to-done = 17 cycles; tt = 16'hAAAA; x changes every cycle.
5. Assert rst at minterm 7 -> next cycle busy = 0, x = 0, tt = 0, no done pulse. A fresh start then completes normally with correct tt.
6. Pulse start during RUN and during FIN -> ignored, sweep length unchanged. start in the cycle after done -> second sweep begins; tt cleared, then re-captured.
